// File: rtl/spi_slave_ctrl.sv
// SPI slave framing controller wrapped around an external shift-register deserializer.
// It sequences command selection, counts frame bits, captures the parallel word as a
// one-cycle rx_valid strobe, and serializes read-back data onto MISO MSB first.
// Optional feature macro: SPI_FRAME_ERR_EN adds a frame_err pulse output for aborted frames.
module spi_slave_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAME_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   des_en,
  output logic                   des_bit,
  input  logic [FRAME_WIDTH-1:0] des_data,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                   frame_err
`endif
);

  localparam int unsigned CntW   = $clog2(FRAME_WIDTH + 1);
  localparam int unsigned TxCntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   rx_done_q, rx_done_d;
  logic [FRAME_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rd_addr_flag_q, rd_addr_flag_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   miso_q, miso_d;

  logic in_frame;
  logic frame_full;
  logic capture;

  assign in_frame   = (state_q == StWrite) || (state_q == StReadAdd) ||
                      (state_q == StReadData);
  assign frame_full = (bit_cnt_q == CntW'(FRAME_WIDTH));
  // Capture happens once per frame even if ss_n rises on the completing edge.
  assign capture    = in_frame && frame_full && !rx_done_q;

  // Next-state, frame counting, capture and MISO serializer.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_done_d      = rx_done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    miso_d         = miso_q;
    des_bit        = mosi;
    des_en         = 1'b0;

    if (in_frame) begin
      des_en = !ss_n && !frame_full;
    end
    if (des_en) begin
      bit_cnt_d = bit_cnt_q + CntW'(1);
    end

    if (capture) begin
      rx_data_d  = des_data;
      rx_valid_d = 1'b1;
      rx_done_d  = 1'b1;
      if (state_q == StReadAdd) begin
        rd_addr_flag_d = 1'b1;
      end else if (state_q == StReadData) begin
        rd_addr_flag_d = 1'b0;
      end
    end

    // Read data is accepted only once the command frame has been delivered.
    if ((state_q == StReadData) && rx_done_q && !tx_busy_q && !tx_done_q && tx_valid) begin
      tx_shift_d = tx_data;
      tx_cnt_d   = '0;
      tx_busy_d  = 1'b1;
    end

    if (tx_busy_q) begin
      if (tx_cnt_q < TxCntW'(DATA_WIDTH)) begin
        miso_d     = tx_shift_q[DATA_WIDTH-1];
        tx_shift_d = tx_shift_q << 1;
        tx_cnt_d   = tx_cnt_q + TxCntW'(1);
      end else begin
        miso_d    = 1'b0;
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (!ss_n) begin
          state_d = StChkCmd;
        end
      end
      StChkCmd: begin
        if (ss_n) begin
          state_d = StIdle;
        end else if (!mosi) begin
          state_d = StWrite;
        end else if (rd_addr_flag_q) begin
          state_d = StReadData;
        end else begin
          state_d = StReadAdd;
        end
      end
      StWrite, StReadAdd, StReadData: begin
        if (ss_n) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Deselect terminates everything except a capture on the same edge.
    if (ss_n && (state_q != StIdle)) begin
      bit_cnt_d = '0;
      rx_done_d = 1'b0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
      miso_d    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      rx_done_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_done_q      <= rx_done_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Flag deselects that cut a frame short or interrupt MISO shift-out.
  always_comb begin
    frame_err_d = 1'b0;
    if (ss_n && in_frame) begin
      frame_err_d = ((bit_cnt_q != '0) && !frame_full) ||
                    ((state_q == StReadData) && tx_busy_q);
    end
  end

  // Frame error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl with a behavioural deserializer and
// scoreboards for captured frames and MISO read-back bits.
module tb_spi_slave_ctrl;
  localparam int DW = 8;
  localparam int FW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic          des_en;
  logic          des_bit;
  logic [FW-1:0] des_data = '0;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err;
  int            err_seen = 0;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FW-1:0] rx_q[$];
  logic          miso_q[$];

  spi_slave_ctrl #(
    .DATA_WIDTH (DW),
    .FRAME_WIDTH(FW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .des_en   (des_en),
    .des_bit  (des_bit),
    .des_data (des_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Deserializer model: MSB-first shift register, never cleared.
  always @(posedge clk) begin
    if (des_en) des_data <= {des_data[FW-2:0], des_bit};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame scoreboard consumer.
  always @(negedge clk) begin
    if (rst === 1'b1 && rx_valid === 1'b1) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected", 32'd1, 32'd0);
      end else begin
        check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
`ifdef SPI_FRAME_ERR_EN
    if (frame_err === 1'b1) err_seen++;
`endif
  end

  // Select, command bit, n payload bits MSB first; full frames get a capture tail.
  task automatic frame(input logic sel, input logic [15:0] bits, input int n,
                       input bit early_end, input bit tx_early);
    logic [15:0] tmp;
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = sel;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mosi     = bits[i];
      tx_valid = tx_early && (i == 5);
      tx_data  = 8'h81;
    end
    if (n >= FW) begin
      tmp = bits >> (n - FW);
      rx_q.push_back(tmp[FW-1:0]);
      @(negedge clk); mosi = 1'b0; tx_valid = 1'b0;
      if (early_end) ss_n = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
  endtask

  // Pulse tx_valid; either expect the serialized byte or a silent MISO.
  task automatic tx_send(input logic [DW-1:0] d, input bit expect_out, input int nchk);
    @(negedge clk); tx_valid = 1'b1; tx_data = d;
    @(negedge clk); tx_valid = 1'b0;
    check("miso_pre", 32'(miso), 32'd0);
    if (expect_out) begin
      for (int i = DW - 1; i >= 0; i--) miso_q.push_back(d[i]);
      miso_q.push_back(1'b0);
      for (int i = 0; i < nchk; i++) begin
        @(negedge clk);
        check("miso_bit", 32'(miso), 32'(miso_q.pop_front()));
      end
    end else begin
      for (int i = 0; i < nchk; i++) begin
        @(negedge clk);
        check("miso_idle", 32'(miso), 32'd0);
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
    #1;
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #12;
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_des_en", 32'(des_en), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Write 0x0A5; MISO must stay low.
    frame(1'b0, 16'h00A5, FW, 1'b0, 1'b0);
    check("write_miso", 32'(miso), 32'd0);
    end_frame();

    // Read address 0x230, then read data 0x300 with 0xC3 returned.
    frame(1'b1, 16'h0230, FW, 1'b0, 1'b0);
    end_frame();
    frame(1'b1, 16'h0300, FW, 1'b0, 1'b0);
    tx_send(8'hC3, 1'b1, DW + 1);
    end_frame();

    // Abort after 5 bits, then a full write must overwrite any residue.
    frame(1'b0, 16'h0015, 5, 1'b0, 1'b0);
    end_frame();
    frame(1'b0, 16'h00F0, FW, 1'b1, 1'b0);
    end_frame();

    // 12 bits in WRITE: only the first 10 are captured.
    frame(1'b0, 16'h0333, 12, 1'b0, 1'b0);
    end_frame();

    // Read address, then read data with an early tx_valid that must be ignored.
    frame(1'b1, 16'h0211, FW, 1'b0, 1'b0);
    end_frame();
    frame(1'b1, 16'h0322, FW, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("miso_wait", 32'(miso), 32'd0);
    end
    tx_send(8'h5A, 1'b1, DW + 1);
    end_frame();

    // Reset in the middle of shift-out after three MISO bits.
    frame(1'b1, 16'h02AA, FW, 1'b0, 1'b0);
    end_frame();
    frame(1'b1, 16'h03FF, FW, 1'b0, 1'b0);
    tx_send(8'hA5, 1'b1, 3);
    miso_q.delete();
    reset_pulse();
    frame(1'b1, 16'h0155, FW, 1'b0, 1'b0);
    tx_send(8'hFF, 1'b0, DW + 1);
    end_frame();

    // Reset drops a pending read-address flag: next read select is an address again.
    reset_pulse();
    frame(1'b1, 16'h00AB, FW, 1'b0, 1'b0);
    tx_send(8'hFF, 1'b0, DW + 1);
    end_frame();

    repeat (3) @(negedge clk);
    check("rx_pending", 32'(rx_q.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_cnt", 32'(err_seen), 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave framing controller that sits directly around the shift-register deserializer.
- Drives the deserializer's enable and serial bit from MOSI, counts frame bits, and captures the parallel word as a one-cycle rx_valid transfer toward the memory side.
- For read transactions, serializes the returned tx_data onto MISO.
- MOSI/SS_n are sampled on the system clock (one bit per clk).

Parameters:
- DATA_WIDTH, 8, payload bits per frame and MISO read-back width.
- FRAME_WIDTH, 10, bits shifted into the deserializer per frame (2 command bits + DATA_WIDTH); must equal deserializer WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ss_n  input  1  slave select, active low
- mosi  input  1  serial data in
- miso  output  1  serial data out, MSB first
- des_en  output  1  deserializer shift enable
- des_bit  output  1  deserializer serial input (mosi passthrough, combinational)
- des_data  input  FRAME_WIDTH  deserializer parallel output
- rx_data  output  FRAME_WIDTH  captured frame
- rx_valid  output  1  one-cycle strobe, rx_data valid
- tx_data  input  DATA_WIDTH  read data from memory side
- tx_valid  input  1  tx_data valid strobe

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - miso, des_en, rx_valid = 0; rx_data = 0.
  - Internal counters and rd_addr_flag = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE -> CHK_CMD on the edge where ss_n=0.
  - CHK_CMD samples mosi (select bit; not shifted):
    - 0 -> WRITE.
    - 1 and rd_addr_flag=0 -> READ_ADD.
    - 1 and rd_addr_flag=1 -> READ_DATA.
- Frame shifting (WRITE/READ_ADD/READ_DATA):
  - des_en = (ss_n==0 && bit_cnt<FRAME_WIDTH), combinational; des_bit = mosi.
  - bit_cnt increments per enabled cycle.
  - At the edge after bit_cnt reaches FRAME_WIDTH: rx_data<=des_data, rx_valid=1 for exactly one cycle.
  - Latency: rx_valid is visible 1 clk after the edge that shifted the last bit.
  - Deserializer is never cleared; exactly FRAME_WIDTH shifts overwrite all bits.
  - Extra mosi bits after a complete frame are ignored (des_en=0).
- WRITE: after rx_valid, hold until ss_n=1.
- READ_ADD: on rx_valid, set rd_addr_flag=1; hold until ss_n=1.
- READ_DATA:
  - On rx_valid, clear rd_addr_flag.
  - Then wait for tx_valid=1; latch tx_data.
  - Starting the next edge, drive miso = tx bit DATA_WIDTH-1 down to 0, one bit per clk, DATA_WIDTH cycles, then miso=0.
  - tx_valid before rx_valid, or while already shifting out, is ignored.
- ss_n=1 in any non-IDLE state:
  - Next state IDLE; bit_cnt and tx counter cleared; miso=0.
  - No rx_valid for an incomplete frame.
  - rd_addr_flag unchanged by an abort.
- ss_n=1 on the same edge as completion (bit_cnt==FRAME_WIDTH): rx_valid still issued, then IDLE.
- Reset mid-operation forces the reset values immediately; rd_addr_flag is lost.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses high one cycle when ss_n rises in WRITE/READ_ADD/READ_DATA with 0 < bit_cnt < FRAME_WIDTH.
  - Also pulses when ss_n rises in READ_DATA during MISO shift-out.
- Undefined: port and logic absent; aborts are silent.

Test Plan:
- Write: ss_n=0, select 0, then 10 bits 00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5, 1 clk after the last bit; miso stays 0.
- Read addr then data, part 1: select 1, bits 10_0011_0000 -> rx_data=10'h230, rd_addr_flag=1.
- Read addr then data, part 2: ss_n cycle, then select 1 + 11_0000_0000 -> state READ_DATA, rx_data=10'h300, flag cleared.
- Read addr then data, part 3: tx_valid with tx_data=8'hC3 -> miso sequence 1,1,0,0,0,0,1,1, then 0.
- Abort: ss_n rises after 5 frame bits -> no rx_valid, IDLE; frame_err pulse if SPI_FRAME_ERR_EN. Following write of 00_1111_0000 -> rx_data=10'h0F0 (no residue).
- Reset: rst=0 mid-READ_DATA shift-out after 3 miso bits -> miso=0 immediately, IDLE. Next read select goes to READ_ADD (flag cleared).
- Edge cases:
  - 12 bits sent in WRITE -> only the first 10 captured, one rx_valid.
  - tx_valid pulsed before rx_valid in READ_DATA -> ignored; miso stays 0 until a later tx_valid.
